// File: rtl/rip_axi_arbiter.sv
// Two-port round-robin arbiter that funnels single-word read/write requests
// from the data memory unit (port 0) and instruction fetch (port 1) onto one AXI4 master.
module rip_axi_arbiter #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 sys_rst_n,
    input  logic [1:0]                           req_valid,
    output logic [1:0]                           req_ready,
    input  logic [1:0]                           req_write,
    input  logic [1:0][AXI_ADDR_WIDTH-1:0]       req_addr,
    input  logic [1:0][AXI_DATA_WIDTH-1:0]       req_wdata,
    input  logic [1:0][AXI_DATA_WIDTH/8-1:0]     req_wstrb,
    output logic [1:0]                           resp_valid,
    output logic [AXI_DATA_WIDTH-1:0]            resp_rdata,
    output logic                                 resp_err,
    output logic                                 busy,
    output logic [AXI_ID_WIDTH-1:0]              m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]            m_axi_awaddr,
    output logic [7:0]                           m_axi_awlen,
    output logic [2:0]                           m_axi_awsize,
    output logic [1:0]                           m_axi_awburst,
    output logic                                 m_axi_awlock,
    output logic [3:0]                           m_axi_awcache,
    output logic [2:0]                           m_axi_awprot,
    output logic [3:0]                           m_axi_awqos,
    output logic [3:0]                           m_axi_awregion,
    output logic                                 m_axi_awvalid,
    input  logic                                 m_axi_awready,
    output logic [AXI_ID_WIDTH-1:0]              m_axi_wid,
    output logic [AXI_DATA_WIDTH-1:0]            m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]          m_axi_wstrb,
    output logic                                 m_axi_wlast,
    output logic                                 m_axi_wvalid,
    input  logic                                 m_axi_wready,
    input  logic [1:0]                           m_axi_bresp,
    input  logic                                 m_axi_bvalid,
    output logic                                 m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]              m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                           m_axi_arlen,
    output logic [2:0]                           m_axi_arsize,
    output logic [1:0]                           m_axi_arburst,
    output logic                                 m_axi_arlock,
    output logic [3:0]                           m_axi_arcache,
    output logic [2:0]                           m_axi_arprot,
    output logic [3:0]                           m_axi_arqos,
    output logic [3:0]                           m_axi_arregion,
    output logic                                 m_axi_arvalid,
    input  logic                                 m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]            m_axi_rdata,
    input  logic [1:0]                           m_axi_rresp,
    input  logic                                 m_axi_rvalid,
    output logic                                 m_axi_rready
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE   = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_WRITE, S_WRESP, S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                grant_c, accept_c;
    logic                gnt_q, last_grant_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
    logic                aw_done_c, w_done_c;
    logic [1:0]          resp_valid_d;

    // Single-beat, incrementing, normal-access transactions only
    assign m_axi_awid     = AXI_ID_WIDTH'(gnt_q);
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = 3'(SIZE);
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'b0011;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_wid      = AXI_ID_WIDTH'(gnt_q);
    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = wstrb_q;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_arid     = AXI_ID_WIDTH'(gnt_q);
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = 3'(SIZE);
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'b0011;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;

    // Next-state, grant and next-value of the registered channel controls
    always_comb begin
        state_d      = state_q;
        req_ready    = 2'b00;
        accept_c     = 1'b0;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        awvalid_d    = 1'b0;
        wvalid_d     = 1'b0;
        bready_d     = 1'b0;
        resp_valid_d = 2'b00;
        aw_done_c    = !m_axi_awvalid || m_axi_awready;
        w_done_c     = !m_axi_wvalid || m_axi_wready;
        grant_c      = (&req_valid) ? !last_grant_q : req_valid[1];
        unique case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    accept_c  = 1'b1;
                    req_ready = grant_c ? 2'b10 : 2'b01;
                    if (req_write[grant_c]) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_RADDR: begin
                arvalid_d = !m_axi_arready;
                rready_d  = m_axi_arready;
                if (m_axi_arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                rready_d = !m_axi_rvalid;
                if (m_axi_rvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = {gnt_q, !gnt_q};
                end
            end
            S_WRITE: begin
                // Each channel drops on its own handshake; leave once both are done
                awvalid_d = !aw_done_c;
                wvalid_d  = !w_done_c;
                if (aw_done_c && w_done_c) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                bready_d = !m_axi_bvalid;
                if (m_axi_bvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = {gnt_q, !gnt_q};
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and channel control registers
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            resp_valid    <= 2'b00;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            resp_valid    <= resp_valid_d;
            busy          <= (state_d != S_IDLE);
        end
    end

    // Request latch and response capture
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            if (accept_c) begin
                gnt_q        <= grant_c;
                last_grant_q <= grant_c;
                addr_q       <= req_addr[grant_c];
                wdata_q      <= req_wdata[grant_c];
                wstrb_q      <= req_wstrb[grant_c];
            end
            if (state_q == S_RDATA && m_axi_rvalid) begin
                resp_rdata <= m_axi_rdata;
                resp_err   <= (m_axi_rresp != 2'b00);
            end
            if (state_q == S_WRESP && m_axi_bvalid) begin
                resp_err <= (m_axi_bresp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_rip_axi_arbiter.sv
// Scoreboard bench for rip_axi_arbiter: queued requesters, an AXI slave model with
// programmable stalls/errors, and an abstract arbitration/response model.
module tb_rip_axi_arbiter;

    localparam int unsigned IDW = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;

    logic clk = 1'b0;
    logic sys_rst_n;
    always #5 clk = ~clk;

    logic [1:0]               req_valid, req_ready, req_write, resp_valid;
    logic [1:0][AW-1:0]       req_addr;
    logic [1:0][DW-1:0]       req_wdata;
    logic [1:0][SW-1:0]       req_wstrb;
    logic [DW-1:0]            resp_rdata;
    logic                     resp_err, busy;
    logic [IDW-1:0]           awid, wid, arid;
    logic [AW-1:0]            awaddr, araddr;
    logic [7:0]               awlen, arlen;
    logic [2:0]               awsize, arsize, awprot, arprot;
    logic [1:0]               awburst, arburst, bresp, rresp;
    logic                     awlock, arlock, awvalid, awready, wlast, wvalid, wready;
    logic                     bvalid, bready, arvalid, arready, rvalid, rready;
    logic [3:0]               awcache, arcache, awqos, arqos, awregion, arregion;
    logic [DW-1:0]            wdata, rdata;
    logic [SW-1:0]            wstrb;

    rip_axi_arbiter #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wid(wid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    typedef struct {
        logic          port;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester sources, scoreboard queues and abstract model state
    req_t src0[$], src1[$];
    req_t exp_q[$];
    rsp_t rsp_q[$];
    req_t held[2];
    logic [1:0] pend;
    logic model_idle, model_last;
    logic [DW-1:0] model_rdata;
    int cycle, grant_cycle;

    // Slave knobs and state
    bit rand_slave, gen_gap, check_lat, force_rdata_en;
    logic [DW-1:0] force_rdata;
    int force_rresp, force_bresp, r_delay_force, ar_stall, aw_stall;
    bit rd_pend, b_pend, aw_got, w_got;
    int rd_dly, b_dly;
    bit ar_wait, aw_wait, w_wait;
    logic [AW-1:0] ar_prev, aw_prev;

    task automatic clear_bench();
        src0.delete(); src1.delete(); exp_q.delete(); rsp_q.delete();
        pend = 2'b00; req_valid = 2'b00; req_write = 2'b00;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        model_idle = 1'b1; model_last = 1'b1; model_rdata = '0;
        rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; rd_dly = 0; b_dly = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; ar_prev = '0; aw_prev = '0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = '0; rresp = 2'b00; bresp = 2'b00;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        clear_bench();
        repeat (2) @(posedge clk);
        #2 sys_rst_n = 1'b1;
    endtask

    function automatic logic [1:0] rand_resp();
        return ($urandom_range(5) < 4) ? 2'b00 : 2'($urandom_range(3));
    endfunction

    always @(negedge clk) begin : engine
        rsp_t s;
        logic g;
        logic [1:0] exp_ready;
        if (sys_rst_n) begin
            cycle++;
            // Requesters: load the next queued request, occasionally withdraw one
            if (!pend[0] && src0.size() > 0 && (!gen_gap || $urandom_range(2) == 0)) begin
                held[0] = src0.pop_front(); pend[0] = 1'b1;
            end
            if (!pend[1] && src1.size() > 0 && (!gen_gap || $urandom_range(2) == 0)) begin
                held[1] = src1.pop_front(); pend[1] = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (gen_gap && pend[p] && $urandom_range(24) == 0) pend[p] = 1'b0;
                req_valid[p] = pend[p];
                req_write[p] = held[p].write;
                req_addr[p]  = held[p].addr;
                req_wdata[p] = held[p].wdata;
                req_wstrb[p] = held[p].wstrb;
            end
            // Slave drive
            if (ar_stall > 0) begin
                arready = 1'b0;
                if (arvalid) ar_stall--;
            end else arready = rand_slave ? 1'($urandom_range(1)) : 1'b1;
            if (aw_stall > 0) begin
                awready = 1'b0;
                if (awvalid) aw_stall--;
            end else awready = rand_slave ? 1'($urandom_range(1)) : 1'b1;
            wready = rand_slave ? 1'($urandom_range(1)) : 1'b1;
            rvalid = rd_pend && (rd_dly == 0);
            if (rd_pend && rd_dly > 0) rd_dly--;
            bvalid = b_pend && (b_dly == 0);
            if (b_pend && b_dly > 0) b_dly--;
            #1;
            check("busy", busy, !model_idle);
            g = (req_valid == 2'b11) ? !model_last : req_valid[1];
            exp_ready = (model_idle && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            check("req_ready", req_ready, exp_ready);
            if (exp_ready != 2'b00) begin
                held[g].port = g;
                exp_q.push_back(held[g]);
                pend[g] = 1'b0;
                model_last = g;
                model_idle = 1'b0;
                grant_cycle = cycle;
            end
            // Read channels
            if (ar_wait) begin
                check("arvalid_hold", arvalid, 1'b1);
                check("araddr_stable", araddr, ar_prev);
            end
            if (arvalid && arready) begin
                if (exp_q.size() == 0 || exp_q[0].write) check("ar_unexpected", 1'b1, 1'b0);
                else begin
                    check("araddr", araddr, exp_q[0].addr);
                    check("arid", arid, 64'(exp_q[0].port));
                    check("ar_fields", {arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion},
                          {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0, 4'd0});
                    rdata = force_rdata_en ? force_rdata : $urandom;
                    rresp = (force_rresp >= 0) ? 2'(force_rresp) : (rand_slave ? rand_resp() : 2'b00);
                    s.port = exp_q[0].port; s.rdata = rdata; s.err = (rresp != 2'b00);
                    rsp_q.push_back(s);
                    model_rdata = rdata;
                    void'(exp_q.pop_front());
                    rd_pend = 1;
                    rd_dly = (r_delay_force >= 0) ? r_delay_force : (rand_slave ? $urandom_range(2) : 0);
                end
            end
            ar_wait = arvalid && !arready;
            ar_prev = araddr;
            if (rvalid && rready) rd_pend = 0;
            // Write channels
            if (aw_wait) begin
                check("awvalid_hold", awvalid, 1'b1);
                check("awaddr_stable", awaddr, aw_prev);
            end
            if (w_wait) check("wvalid_hold", wvalid, 1'b1);
            if (w_got && !b_pend) check("wvalid_after_hs", wvalid, 1'b0);
            if (bready) check("bready_early", {aw_got, w_got}, 2'b11);
            if (awvalid && awready) begin
                if (exp_q.size() == 0 || !exp_q[0].write || aw_got) check("aw_unexpected", 1'b1, 1'b0);
                else begin
                    check("awaddr", awaddr, exp_q[0].addr);
                    check("awid", awid, 64'(exp_q[0].port));
                    check("aw_fields", {awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion},
                          {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0, 4'd0});
                    aw_got = 1;
                end
            end
            if (wvalid && wready) begin
                if (exp_q.size() == 0 || !exp_q[0].write || w_got) check("w_unexpected", 1'b1, 1'b0);
                else begin
                    check("wdata", wdata, exp_q[0].wdata);
                    check("wstrb_wlast_wid", {wstrb, wlast, wid}, {exp_q[0].wstrb, 1'b1, 4'(exp_q[0].port)});
                    w_got = 1;
                end
            end
            aw_wait = awvalid && !awready;
            aw_prev = awaddr;
            w_wait  = wvalid && !wready;
            if (aw_got && w_got && !b_pend) begin
                bresp = (force_bresp >= 0) ? 2'(force_bresp) : (rand_slave ? rand_resp() : 2'b00);
                s.port = exp_q[0].port; s.rdata = model_rdata; s.err = (bresp != 2'b00);
                rsp_q.push_back(s);
                void'(exp_q.pop_front());
                b_pend = 1;
                b_dly = rand_slave ? $urandom_range(2) : 0;
            end else if (bvalid && bready) begin
                b_pend = 0; aw_got = 0; w_got = 0;
            end
            // Response monitor
            if (resp_valid != 2'b00) begin
                if (rsp_q.size() == 0) check("resp_spurious", resp_valid, 2'b00);
                else begin
                    s = rsp_q.pop_front();
                    check("resp_valid", resp_valid, s.port ? 2'b10 : 2'b01);
                    check("resp_rdata", resp_rdata, s.rdata);
                    check("resp_err", resp_err, s.err);
                    if (check_lat) check("resp_latency", 64'(cycle - grant_cycle), 64'd3);
                end
                model_idle = 1'b1;
            end
        end
    end

    task automatic push_req(input logic port, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] st);
        req_t r;
        r.port = port; r.write = wr; r.addr = a; r.wdata = d; r.wstrb = st;
        if (port) src1.push_back(r); else src0.push_back(r);
    endtask

    task automatic wait_done(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            done = src0.size() == 0 && src1.size() == 0 && pend == 2'b00 && exp_q.size() == 0 &&
                   rsp_q.size() == 0 && model_idle && !rd_pend && !b_pend;
        end
        if (!done) check("timeout", 1'b0, 1'b1);
    endtask

    task automatic reset_knobs();
        rand_slave = 0; gen_gap = 0; check_lat = 0; force_rdata_en = 0; force_rdata = '0;
        force_rresp = -1; force_bresp = -1; r_delay_force = -1; ar_stall = 0; aw_stall = 0;
    endtask

    initial begin
        cycle = 0; grant_cycle = 0;
        reset_knobs();
        do_reset();
        check("rst_resp", {resp_valid, resp_rdata, resp_err, busy}, '0);
        check("rst_axi_valid_ready", {arvalid, awvalid, wvalid, rready, bready}, '0);
        check("rst_req_ready", req_ready, 2'b00);

        // Single read at minimum latency
        check_lat = 1; force_rdata_en = 1; force_rdata = 32'hDEADBEEF;
        push_req(1'b0, 1'b0, 32'h1000, '0, '0);
        wait_done(50);
        force_rdata_en = 0;

        // Simultaneous requests from reset, then continuous alternation
        do_reset();
        push_req(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        push_req(1'b1, 1'b0, 32'h40, '0, '0);
        for (int i = 0; i < 3; i++) begin
            push_req(1'b0, 1'(i & 1), 32'h100 + 32'(i * 4), $urandom, 4'($urandom));
            push_req(1'b1, 1'(~i & 1), 32'h200 + 32'(i * 4), $urandom, 4'($urandom));
        end
        wait_done(200);

        // Error responses
        force_rresp = 2; push_req(1'b1, 1'b0, 32'h300, '0, '0); wait_done(50);
        force_rresp = -1; force_bresp = 3; push_req(1'b0, 1'b1, 32'h304, 32'hCAFEF00D, 4'h3); wait_done(50);
        force_bresp = -1; check_lat = 0;

        // Split write handshakes: W completes three cycles before AW
        aw_stall = 3; push_req(1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hC); wait_done(50);

        // AR backpressure with port 1 waiting
        ar_stall = 5; push_req(1'b0, 1'b0, 32'h500, '0, '0);
        @(posedge clk); push_req(1'b1, 1'b0, 32'h504, '0, '0);
        wait_done(100);

        // Reset during RDATA
        r_delay_force = 6; push_req(1'b0, 1'b0, 32'h600, '0, '0);
        for (int i = 0; i < 40 && !rready; i++) begin
            @(posedge clk); #2;
        end
        check("mid_read_rready", rready, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_resp", {resp_valid, resp_rdata, resp_err, busy}, '0);
        check("mid_rst_axi", {arvalid, awvalid, wvalid, rready, bready}, '0);
        clear_bench();
        r_delay_force = -1;
        repeat (2) @(posedge clk);
        check("mid_rst_no_pulse", resp_valid, 2'b00);
        #2 sys_rst_n = 1'b1;
        push_req(1'b1, 1'b0, 32'h700, '0, '0);
        wait_done(50);

        // Randomized traffic and slave timing
        rand_slave = 1; gen_gap = 1;
        for (int i = 0; i < 30; i++) begin
            push_req(1'b0, 1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
            push_req(1'b1, 1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
        end
        wait_done(6000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
